// File: rtl/polytris_key_pkg.sv
// -----------------------------------------------------------------------------
// polytris_key_pkg
//
// Purpose: shared definitions for the POLYTRIS keyboard path.
//   - USB HID keycode constants for every key the game reacts to.
//   - Game-action bit indices (ACT_LEFT .. ACT_PAUSE) and ACTION_W.
//   - The key FSM state enum.
//   - decode_keycode(): HID keycode -> {valid, action index}.
//   - is_repeatable(): true for the actions that use DAS/ARR auto-repeat.
//
// Ports: none (package).
// -----------------------------------------------------------------------------
package polytris_key_pkg;

    localparam int ACTION_W = 8;

    // HID usage IDs (keyboard page)
    localparam logic [7:0] KC_NONE        = 8'h00;
    localparam logic [7:0] KC_A           = 8'h04;
    localparam logic [7:0] KC_C           = 8'h06;
    localparam logic [7:0] KC_D           = 8'h07;
    localparam logic [7:0] KC_P           = 8'h13;
    localparam logic [7:0] KC_S           = 8'h16;
    localparam logic [7:0] KC_X           = 8'h1B;
    localparam logic [7:0] KC_Z           = 8'h1D;
    localparam logic [7:0] KC_ESC         = 8'h29;
    localparam logic [7:0] KC_SPACE       = 8'h2C;
    localparam logic [7:0] KC_ARROW_RIGHT = 8'h4F;
    localparam logic [7:0] KC_ARROW_LEFT  = 8'h50;
    localparam logic [7:0] KC_ARROW_DOWN  = 8'h51;
    localparam logic [7:0] KC_ARROW_UP    = 8'h52;

    // Bit positions inside the action pulse vector
    localparam logic [2:0] ACT_LEFT      = 3'd0;
    localparam logic [2:0] ACT_RIGHT     = 3'd1;
    localparam logic [2:0] ACT_SOFT_DROP = 3'd2;
    localparam logic [2:0] ACT_HARD_DROP = 3'd3;
    localparam logic [2:0] ACT_ROT_CW    = 3'd4;
    localparam logic [2:0] ACT_ROT_CCW   = 3'd5;
    localparam logic [2:0] ACT_HOLD      = 3'd6;
    localparam logic [2:0] ACT_PAUSE     = 3'd7;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        DAS_WAIT = 2'd1,
        REPEAT   = 2'd2,
        ONESHOT  = 2'd3
    } key_state_e;

    typedef struct packed {
        logic       valid;
        logic [2:0] idx;
    } key_dec_t;

    function automatic key_dec_t decode_keycode(input logic [7:0] kc);
        key_dec_t d;
        d.valid = 1'b1;
        d.idx   = ACT_LEFT;
        case (kc)
            KC_ARROW_LEFT,  KC_A: d.idx = ACT_LEFT;
            KC_ARROW_RIGHT, KC_D: d.idx = ACT_RIGHT;
            KC_ARROW_DOWN,  KC_S: d.idx = ACT_SOFT_DROP;
            KC_SPACE:             d.idx = ACT_HARD_DROP;
            KC_ARROW_UP,    KC_X: d.idx = ACT_ROT_CW;
            KC_Z:                 d.idx = ACT_ROT_CCW;
            KC_C:                 d.idx = ACT_HOLD;
            KC_P,           KC_ESC: d.idx = ACT_PAUSE;
            default:              d.valid = 1'b0;
        endcase
        return d;
    endfunction

    function automatic logic is_repeatable(input logic [2:0] idx);
        return (idx == ACT_LEFT) || (idx == ACT_RIGHT) || (idx == ACT_SOFT_DROP);
    endfunction

endpackage

// File: rtl/key_repeat_timer.sv
// -----------------------------------------------------------------------------
// key_repeat_timer
//
// Purpose: loadable down-counter used for the DAS and ARR intervals. A load
// strobe takes priority; otherwise the count decrements and saturates at 0.
//
// Ports:
//   clk         in   system clock
//   reset_n     in   asynchronous active-low reset (count -> 0)
//   load_i      in   load strobe
//   load_val_i  in   value loaded when load_i is high
//   zero_o      out  count is 0
// -----------------------------------------------------------------------------
module key_repeat_timer #(
    parameter int unsigned CNT_W = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             load_i,
    input  logic [CNT_W-1:0] load_val_i,
    output logic             zero_o
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/keycode_action_decoder.sv
// -----------------------------------------------------------------------------
// keycode_action_decoder
//
// Purpose: turns the level-valued HID keycode written by the NIOS II into
// single-cycle game-action pulses. Movement keys (left/right/soft drop) get
// delayed auto-shift then auto-repeat; every other mapped key fires once per
// press. Any change of keycode counts as a new press.
//
// Build option: define KEYCODE_AUTOREPEAT_EN to get DAS/ARR repeat. Without
// it every mapped key is one-shot, the repeat timer is not built and the
// DAS_CYCLES/ARR_CYCLES parameters have no effect.
//
// Ports:
//   clk       in   system clock (50 MHz)
//   reset_n   in   asynchronous active-low reset
//   keycode   in   [7:0] HID keycode level, 0x00 = no key
//   enable    in   low suppresses all pulses and returns the FSM to IDLE
//   action    out  [7:0] one-hot, one-clock action pulse
//   key_held  out  a mapped key is registered and enable is high
//
// Latency: keycode -> kc_q (1 clock) -> action/key_held (1 clock).
// -----------------------------------------------------------------------------
module keycode_action_decoder
    import polytris_key_pkg::*;
#(
    parameter int unsigned DAS_CYCLES = 13_333_333,
    parameter int unsigned ARR_CYCLES = 5_000_000
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [7:0]          keycode,
    input  logic                enable,
    output logic [ACTION_W-1:0] action,
    output logic                key_held
);

    logic [7:0]          kc_q;
    logic [7:0]          kc_act_q;
    logic [7:0]          kc_act_d;
    key_state_e          state_q;
    key_state_e          state_d;
    logic [ACTION_W-1:0] action_q;
    logic [ACTION_W-1:0] action_d;
    logic                key_held_q;
    logic                key_held_d;

    key_dec_t            dec;
    logic                key_change;
    logic [ACTION_W-1:0] new_pulse;

    assign dec        = decode_keycode(kc_q);
    // kc_act only ever holds a mapped key or 0x00, so in IDLE any mapped
    // kc_q shows up as a change and fires the initial pulse.
    assign key_change = (kc_q != kc_act_q);
    assign new_pulse  = {{(ACTION_W-1){1'b0}}, 1'b1} << dec.idx;

`ifdef KEYCODE_AUTOREPEAT_EN
    localparam int unsigned MAX_CYCLES = (DAS_CYCLES > ARR_CYCLES) ? DAS_CYCLES : ARR_CYCLES;
    localparam int unsigned CNT_W      = $clog2(MAX_CYCLES);
    // Loading N-1 puts the zero flag N clocks after the loading pulse.
    localparam logic [CNT_W-1:0] DAS_LOAD = CNT_W'(DAS_CYCLES - 1);
    localparam logic [CNT_W-1:0] ARR_LOAD = CNT_W'(ARR_CYCLES - 1);

    logic             tmr_load;
    logic [CNT_W-1:0] tmr_load_val;
    logic             tmr_zero;

    key_repeat_timer #(
        .CNT_W (CNT_W)
    ) u_timer (
        .clk        (clk),
        .reset_n    (reset_n),
        .load_i     (tmr_load),
        .load_val_i (tmr_load_val),
        .zero_o     (tmr_zero)
    );
`else
    logic unused_cfg;
    assign unused_cfg = ^{DAS_CYCLES, ARR_CYCLES};
`endif

    always_comb begin
        state_d    = state_q;
        kc_act_d   = kc_act_q;
        action_d   = '0;
        key_held_d = enable & dec.valid;
`ifdef KEYCODE_AUTOREPEAT_EN
        tmr_load     = 1'b0;
        tmr_load_val = DAS_LOAD;
`endif
        if (!enable) begin
            state_d  = IDLE;
            kc_act_d = '0;
        end else if (key_change) begin
            // A key change overrides any repeat due this cycle.
            if (dec.valid) begin
                action_d = new_pulse;
                kc_act_d = kc_q;
`ifdef KEYCODE_AUTOREPEAT_EN
                if (is_repeatable(dec.idx)) begin
                    state_d      = DAS_WAIT;
                    tmr_load     = 1'b1;
                    tmr_load_val = DAS_LOAD;
                end else begin
                    state_d = ONESHOT;
                end
`else
                state_d = ONESHOT;
`endif
            end else begin
                state_d  = IDLE;
                kc_act_d = '0;
            end
        end
`ifdef KEYCODE_AUTOREPEAT_EN
        else begin
            case (state_q)
                DAS_WAIT: begin
                    if (tmr_zero) begin
                        action_d     = new_pulse;
                        state_d      = REPEAT;
                        tmr_load     = 1'b1;
                        tmr_load_val = ARR_LOAD;
                    end
                end
                REPEAT: begin
                    if (tmr_zero) begin
                        action_d     = new_pulse;
                        tmr_load     = 1'b1;
                        tmr_load_val = ARR_LOAD;
                    end
                end
                default: ;
            endcase
        end
`endif
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            kc_q       <= '0;
            kc_act_q   <= '0;
            state_q    <= IDLE;
            action_q   <= '0;
            key_held_q <= 1'b0;
        end else begin
            kc_q       <= keycode;
            kc_act_q   <= kc_act_d;
            state_q    <= state_d;
            action_q   <= action_d;
            key_held_q <= key_held_d;
        end
    end

    assign action   = action_q;
    assign key_held = key_held_q;

endmodule

// File: tb/tb_keycode_action_decoder.sv
// -----------------------------------------------------------------------------
// tb_keycode_action_decoder
//
// Directed bench for keycode_action_decoder with DAS_CYCLES=10, ARR_CYCLES=4.
// A time-based model (press start edge + interval arithmetic) predicts action
// and key_held for every clock; hand-computed pulse schedules per scenario
// pin that model. Follows KEYCODE_AUTOREPEAT_EN the same way as the design.
// -----------------------------------------------------------------------------
module tb_keycode_action_decoder;

    localparam int DAS = 10;
    localparam int ARR = 4;
`ifdef KEYCODE_AUTOREPEAT_EN
    localparam bit AUTOREP = 1'b1;
`else
    localparam bit AUTOREP = 1'b0;
`endif

    // ---------------- clock / reset / DUT ----------------
    logic       clk;
    logic       reset_n;
    logic [7:0] keycode;
    logic       enable;
    logic [7:0] action;
    logic       key_held;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    keycode_action_decoder #(
        .DAS_CYCLES (DAS),
        .ARR_CYCLES (ARR)
    ) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .keycode  (keycode),
        .enable   (enable),
        .action   (action),
        .key_held (key_held)
    );

    // ---------------- bookkeeping ----------------
    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual === expected) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    // ---------------- model ----------------
    function automatic logic [7:0] key_to_action(input logic [7:0] kc);
        case (kc)
            8'h50, 8'h04: return 8'b0000_0001;
            8'h4F, 8'h07: return 8'b0000_0010;
            8'h51, 8'h16: return 8'b0000_0100;
            8'h2C:        return 8'b0000_1000;
            8'h52, 8'h1B: return 8'b0001_0000;
            8'h1D:        return 8'b0010_0000;
            8'h06:        return 8'b0100_0000;
            8'h13, 8'h29: return 8'b1000_0000;
            default:      return 8'h00;
        endcase
    endfunction

    int         edge_cnt  = 0;
    logic [7:0] m_kcq     = 8'h00;  // keycode as seen one clock ago
    logic [7:0] m_active  = 8'h00;  // key whose press is in progress
    int         m_t0      = 0;      // edge of that press's initial pulse
    logic [7:0] m_exp_act = 8'h00;
    logic       m_exp_held = 1'b0;

    int         log_edge_q[$];
    logic [7:0] log_act_q[$];

    // Compare process: one model step per rising edge, check #1 later.
    always @(posedge clk) begin
        int d;
        edge_cnt++;
        m_exp_act  = 8'h00;
        m_exp_held = 1'b0;
        if (!reset_n) begin
            m_kcq    = 8'h00;
            m_active = 8'h00;
        end else begin
            if (!enable) begin
                m_active = 8'h00;
            end else if (key_to_action(m_kcq) != 8'h00) begin
                m_exp_held = 1'b1;
                if (m_kcq != m_active) begin
                    m_exp_act = key_to_action(m_kcq);
                    m_active  = m_kcq;
                    m_t0      = edge_cnt;
                end else if (AUTOREP && ((key_to_action(m_kcq) & 8'h07) != 8'h00)) begin
                    d = edge_cnt - m_t0;
                    if (d >= DAS && ((d - DAS) % ARR) == 0) m_exp_act = key_to_action(m_kcq);
                end
            end else begin
                m_active = 8'h00;
            end
            m_kcq = keycode;
        end
        #1;
        check("cycle_action", action, m_exp_act);
        check("cycle_key_held", key_held, m_exp_held);
        if (action != 8'h00) begin
            log_edge_q.push_back(edge_cnt);
            log_act_q.push_back(action);
        end
    end

    // ---------------- driver tasks ----------------
    int         base = 0;
    logic [15:0] exp_q[$];
    logic [7:0]  exp_act_q[$];

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic start_test(input logic [7:0] kc);
        log_edge_q.delete();
        log_act_q.delete();
        exp_q.delete();
        exp_act_q.delete();
        keycode = kc;
        base    = edge_cnt;
    endtask

    task automatic push_exp(input int off, input logic [7:0] act);
        exp_q.push_back(16'(off));
        exp_act_q.push_back(act);
    endtask

    task automatic release_key();
        keycode = 8'h00;
        tick(4);
    endtask

    // Scoreboard: observed pulse schedule against the hand-computed one.
    task automatic check_log(input string name);
        check({name, "_count"}, log_edge_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < log_edge_q.size(); i++) begin
            check($sformatf("%s_edge%0d", name, i), log_edge_q[i] - base, {16'h0, exp_q[i]});
            check($sformatf("%s_act%0d", name, i), {24'h0, log_act_q[i]}, {24'h0, exp_act_q[i]});
        end
    endtask

    // ---------------- stimulus ----------------
    logic [7:0] sweep_tbl[16];

    initial begin
        reset_n = 1'b0;
        keycode = 8'h00;
        enable  = 1'b1;
        sweep_tbl = '{8'h04, 8'h07, 8'h16, 8'h52, 8'h1B, 8'h1D, 8'h06, 8'h13,
                      8'h29, 8'h00, 8'hFF, 8'h2C, 8'h05, 8'h50, 8'h4F, 8'h51};
        tick(3);
        check("reset_action", action, 8'h00);
        check("reset_key_held", key_held, 1'b0);
        reset_n = 1'b1;
        tick(2);

        // Left held 30 clocks
        start_test(8'h50);
        tick(30);
        push_exp(2, 8'h01);
        if (AUTOREP) begin
            push_exp(12, 8'h01); push_exp(16, 8'h01); push_exp(20, 8'h01);
            push_exp(24, 8'h01); push_exp(28, 8'h01);
        end
        check_log("left_hold");
        release_key();

        // Hard drop held 30 clocks: one-shot
        start_test(8'h2C);
        tick(30);
        push_exp(2, 8'h08);
        check_log("hard_drop_hold");
        check("hard_drop_key_held", key_held, 1'b1);
        release_key();

        // Left 12 clocks then right directly
        start_test(8'h50);
        tick(12);
        keycode = 8'h4F;
        tick(18);
        push_exp(2, 8'h01);
        if (AUTOREP) push_exp(12, 8'h01);
        push_exp(14, 8'h02);
        if (AUTOREP) begin
            push_exp(24, 8'h02); push_exp(28, 8'h02);
        end
        check_log("left_to_right");
        release_key();

        // Right held, reset pulsed mid-DAS
        start_test(8'h4F);
        tick(7);
        reset_n = 1'b0;
        #1;
        check("async_reset_action", action, 8'h00);
        check("async_reset_key_held", key_held, 1'b0);
        tick(2);
        reset_n = 1'b1;
        tick(21);
        push_exp(2, 8'h02);
        push_exp(11, 8'h02);
        if (AUTOREP) begin
            push_exp(21, 8'h02); push_exp(25, 8'h02); push_exp(29, 8'h02);
        end
        check_log("reset_mid_das");
        release_key();

        // Soft drop held, enable low for a while
        start_test(8'h51);
        tick(4);
        enable = 1'b0;
        tick(17);
        enable = 1'b1;
        tick(19);
        push_exp(2, 8'h04);
        push_exp(22, 8'h04);
        if (AUTOREP) begin
            push_exp(32, 8'h04); push_exp(36, 8'h04); push_exp(40, 8'h04);
        end
        check_log("enable_gap");
        release_key();

        // One-clock glitch to 0x00 between identical keycodes
        start_test(8'h50);
        tick(5);
        keycode = 8'h00;
        tick(1);
        keycode = 8'h50;
        tick(14);
        push_exp(2, 8'h01);
        push_exp(8, 8'h01);
        if (AUTOREP) push_exp(18, 8'h01);
        check_log("glitch");
        release_key();

        // Unmapped keycode
        start_test(8'h33);
        tick(10);
        check_log("unmapped");
        check("unmapped_key_held", key_held, 1'b0);
        release_key();

        // Keycode sweep with direct changes; per-cycle model does the checking
        for (int i = 0; i < 16; i++) begin
            keycode = sweep_tbl[i];
            tick(3);
        end
        release_key();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
